// File: rtl/periph_bus_ctrl_pkg.sv
// Shared constants, types and helpers for the peripheral bus controller.
package periph_bus_ctrl_pkg;

    localparam int unsigned ADDR_W     = 30;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BE_W       = 4;
    localparam int unsigned REGION_W   = 8;
    localparam int unsigned NUM_SLAVES = 5;
    localparam int unsigned ERR_CNT_W  = 8;

    // Region codes taken from address[29:22]
    localparam logic [REGION_W-1:0] REG_ROM  = 8'h00;
    localparam logic [REGION_W-1:0] REG_RAM  = 8'h10;
    localparam logic [REGION_W-1:0] REG_UART = 8'h80;
    localparam logic [REGION_W-1:0] REG_GPIO = 8'h81;
    localparam logic [REGION_W-1:0] REG_SPI  = 8'h82;

    // Bit position of each slave in the one-hot select / ready vectors
    typedef enum int unsigned {
        SL_ROM  = 0,
        SL_RAM  = 1,
        SL_UART = 2,
        SL_GPIO = 3,
        SL_SPI  = 4
    } slave_idx_e;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    // Latched CPU request presented to the slaves
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic              we;
        logic              re;
    } bus_req_t;

    // Error counter increment that sticks at all-ones
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/periph_bus_ctrl_if.sv
// CPU-side data bus between the CPU (master) and the bus controller (slave).
interface periph_bus_ctrl_if;
    import periph_bus_ctrl_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              writeenable;
    logic              readenable;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteena;
    logic [DATA_W-1:0] readdata;
    logic              ack;
    logic              bus_err;

    modport master (
        output address, writeenable, readenable, writedata, byteena,
        input  readdata, ack, bus_err
    );

    modport slave (
        input  address, writeenable, readenable, writedata, byteena,
        output readdata, ack, bus_err
    );

endinterface

// File: rtl/periph_bus_ctrl_bus_addr_decode.sv
// Region code to one-hot slave select; purely combinational.
module periph_bus_ctrl_bus_addr_decode
    import periph_bus_ctrl_pkg::*;
(
    input  logic [REGION_W-1:0]   region,
    output logic [NUM_SLAVES-1:0] sel_c,
    output logic                  mapped_c
);

    // Map each known region to its slave bit; anything else selects nothing
    always_comb begin
        sel_c = '0;
        case (region)
            REG_ROM:  sel_c[SL_ROM]  = 1'b1;
            REG_RAM:  sel_c[SL_RAM]  = 1'b1;
            REG_UART: sel_c[SL_UART] = 1'b1;
            REG_GPIO: sel_c[SL_GPIO] = 1'b1;
            REG_SPI:  sel_c[SL_SPI]  = 1'b1;
            default:  sel_c = '0;
        endcase
        mapped_c = |sel_c;
    end

endmodule

// File: rtl/periph_bus_ctrl.sv
// Sequences CPU data-bus accesses onto the peripheral slaves with
// error completion for unmapped, illegal and timed-out accesses.
module periph_bus_ctrl
    import periph_bus_ctrl_pkg::*;
#(
    parameter int unsigned       TIMEOUT   = 16,
    parameter logic [DATA_W-1:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    periph_bus_ctrl_if.slave             cpu,
    output logic [ERR_CNT_W-1:0]         err_count,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic                         s_we,
    output logic                         s_re,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [BE_W-1:0]              s_be,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ready
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]            state;
    logic [1:0]            state_d;
    logic [CNT_W-1:0]      cnt;
    bus_req_t              req_q;
    logic [DATA_W-1:0]     readdata_q;
    logic                  ack_q;
    logic                  bus_err_q;

    logic [NUM_SLAVES-1:0] dec_sel_c;
    logic                  dec_mapped_c;
    logic                  req_c;
    logic                  legal_c;
    logic                  sel_ready_c;
    logic [DATA_W-1:0]     sel_rdata_c;

    periph_bus_ctrl_bus_addr_decode u_decode (
        .region   (cpu.address[ADDR_W-1 -: REGION_W]),
        .sel_c    (dec_sel_c),
        .mapped_c (dec_mapped_c)
    );

    assign req_c       = cpu.readenable | cpu.writeenable;
    assign legal_c     = dec_mapped_c & ~(cpu.readenable & cpu.writeenable);
    assign sel_ready_c = |(s_ready & s_sel);

    assign s_addr      = req_q.addr;
    assign s_wdata     = req_q.wdata;
    assign s_be        = req_q.be;
    assign cpu.readdata = readdata_q;
    assign cpu.ack      = ack_q;
    assign cpu.bus_err  = bus_err_q;

    // Read data of the currently selected slave (zero when none selected)
    always_comb begin
        sel_rdata_c = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (s_sel[i]) begin
                sel_rdata_c = sel_rdata_c | s_rdata[DATA_W*i +: DATA_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; ready wins over timeout in the same cycle
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (req_c) begin
                    state_d = legal_c ? ST_WAIT : ST_ERR;
                end
            end
            ST_WAIT: begin
                if (sel_ready_c) begin
                    state_d = ST_DONE;
                end else if (cnt == CNT_LAST) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: request latch, strobes, timeout counter, completion and error count
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_q      <= '0;
            s_sel      <= '0;
            s_we       <= 1'b0;
            s_re       <= 1'b0;
            cnt        <= '0;
            readdata_q <= '0;
            ack_q      <= 1'b0;
            bus_err_q  <= 1'b0;
            err_count  <= '0;
        end else begin
            s_we      <= 1'b0;
            s_re      <= 1'b0;
            ack_q     <= 1'b0;
            bus_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_c) begin
                        req_q.addr  <= cpu.address;
                        req_q.wdata <= cpu.writedata;
                        req_q.be    <= cpu.byteena;
                        req_q.we    <= cpu.writeenable;
                        req_q.re    <= cpu.readenable;
                        cnt         <= '0;
                    end
                    if (state_d == ST_WAIT) begin
                        s_sel <= dec_sel_c;
                        s_we  <= cpu.writeenable;
                        s_re  <= cpu.readenable;
                    end else if (state_d == ST_ERR) begin
                        ack_q     <= 1'b1;
                        bus_err_q <= 1'b1;
                        err_count <= sat_inc(err_count);
                        if (cpu.readenable) begin
                            readdata_q <= ERR_RDATA;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (state_d == ST_DONE) begin
                        s_sel <= '0;
                        ack_q <= 1'b1;
                        if (req_q.re & ~req_q.we) begin
                            readdata_q <= sel_rdata_c;
                        end
                    end else if (state_d == ST_ERR) begin
                        s_sel     <= '0;
                        ack_q     <= 1'b1;
                        bus_err_q <= 1'b1;
                        err_count <= sat_inc(err_count);
                        if (req_q.re) begin
                            readdata_q <= ERR_RDATA;
                        end
                    end
                end
                default: begin
                    s_sel <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Randomized self-checking bench for periph_bus_ctrl against a cycle-count reference model.
module tb_periph_bus_ctrl;

    localparam int          TO      = 16;
    localparam logic [31:0] ERR_VAL = 32'hDEADBEEF;

    logic         clk;
    logic         reset_n;
    logic [7:0]   err_count;
    logic [4:0]   s_sel;
    logic         s_we;
    logic         s_re;
    logic [29:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_be;
    logic [159:0] s_rdata;
    logic [4:0]   s_ready;

    periph_bus_ctrl_if bus ();

    periph_bus_ctrl #(.TIMEOUT(TO), .ERR_RDATA(ERR_VAL)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu       (bus),
        .err_count (err_count),
        .s_sel     (s_sel),
        .s_we      (s_we),
        .s_re      (s_re),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_be      (s_be),
        .s_rdata   (s_rdata),
        .s_ready   (s_ready)
    );

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;

    // Reference model state
    logic [31:0] exp_rdata = '0;
    int          exp_errs  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Slave index of a region, -1 when unmapped
    function automatic int region_slave(input logic [7:0] r);
        case (r)
            8'h00:   return 0;
            8'h10:   return 1;
            8'h80:   return 2;
            8'h81:   return 3;
            8'h82:   return 4;
            default: return -1;
        endcase
    endfunction

    // One full CPU access; called at a negedge, returns at a negedge.
    // dly = cycles after the strobe cycle before the selected slave raises ready.
    task automatic access(input logic [7:0] region, input logic we, input logic re,
                          input logic [31:0] wdata, input logic [3:0] be, input int dly);
        logic [29:0] addr;
        logic [31:0] rd;
        logic [4:0]  onehot;
        int          idx;
        bit          ok;
        bit          exp_err;
        int          ack_edge;
        int          we_cnt;
        int          re_cnt;
        int          sel_bad;
        bit          got;
        addr    = {region, 22'($urandom)};
        rd      = $urandom;
        idx     = region_slave(region);
        ok      = (idx >= 0) && !(we && re);
        onehot  = ok ? 5'(1 << idx) : 5'd0;
        exp_err = !ok || (dly + 2 > TO + 1);
        ack_edge = !ok ? 1 : (exp_err ? TO + 1 : dly + 2);
        we_cnt  = 0;
        re_cnt  = 0;
        sel_bad = 0;
        got     = 1'b0;

        for (int i = 0; i < 5; i++) s_rdata[32*i +: 32] = $urandom;
        if (ok) s_rdata[32*idx +: 32] = rd;
        s_ready = 5'($urandom) & ~onehot;
        bus.address     = addr;
        bus.writeenable = we;
        bus.readenable  = re;
        bus.writedata   = wdata;
        bus.byteena     = be;

        for (int n = 1; n <= TO + 4; n++) begin
            @(posedge clk);
            @(negedge clk);
            we_cnt += int'(s_we);
            re_cnt += int'(s_re);
            if (n == 1 && ok) begin
                check_eq("s_addr", 32'(s_addr), 32'(addr));
                check_eq("s_wdata", s_wdata, wdata);
                check_eq("s_be", 32'(s_be), 32'(be));
            end
            if (bus.ack) begin
                got = 1'b1;
                check_eq("ack_latency", 32'(n), 32'(ack_edge));
                break;
            end
            if (s_sel !== onehot) sel_bad++;
            s_ready = 5'($urandom) & ~onehot;
            if (ok && n == dly + 1) s_ready = s_ready | onehot;
        end

        if (!got) begin
            check_eq("ack_timeout", 32'(0), 32'(1));
        end else begin
            if (exp_err) begin
                exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
                if (re) exp_rdata = ERR_VAL;
            end else if (re) begin
                exp_rdata = rd;
            end
            check_eq("bus_err", 32'(bus.bus_err), 32'(exp_err));
            check_eq("readdata", bus.readdata, exp_rdata);
            check_eq("err_count", 32'(err_count), 32'(exp_errs));
            check_eq("s_sel_clr", 32'(s_sel), 32'(0));
        end

        bus.writeenable = 1'b0;
        bus.readenable  = 1'b0;
        s_ready = 5'($urandom);
        @(posedge clk);
        @(negedge clk);
        we_cnt += int'(s_we);
        re_cnt += int'(s_re);
        check_eq("ack_pulse", 32'({bus.ack, bus.bus_err}), 32'(0));
        check_eq("s_sel_hold", 32'(sel_bad), 32'(0));
        check_eq("s_we_pulses", 32'(we_cnt), 32'(ok && we));
        check_eq("s_re_pulses", 32'(re_cnt), 32'(ok && re));
    endtask

    // Hard stop in case something upstream never returns
    initial begin
        #2ms;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mapped_regions [5];
        logic [7:0] r;
        logic       we;
        logic       re;
        int         k;
        mapped_regions = '{8'h00, 8'h10, 8'h80, 8'h81, 8'h82};

        reset_n         = 1'b0;
        bus.address     = '0;
        bus.writeenable = 1'b0;
        bus.readenable  = 1'b0;
        bus.writedata   = '0;
        bus.byteena     = '0;
        s_rdata         = '0;
        s_ready         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_readdata", bus.readdata, 32'(0));
        check_eq("rst_ack_err", 32'({bus.ack, bus.bus_err}), 32'(0));
        check_eq("rst_sel_strb", 32'({s_sel, s_we, s_re}), 32'(0));
        check_eq("rst_err_count", 32'(err_count), 32'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Directed: RAM read, GPIO write, unmapped read, UART timeout, illegal
        access(8'h10, 1'b0, 1'b1, 32'h0, 4'hF, 1);
        access(8'h81, 1'b1, 1'b0, 32'h000000A5, 4'b0001, 3);
        access(8'h40, 1'b0, 1'b1, 32'h0, 4'hF, 1);
        access(8'h80, 1'b0, 1'b1, 32'h0, 4'hF, 1000);
        access(8'h00, 1'b1, 1'b1, 32'h11111111, 4'hF, 1);
        // Ready on the last timeout cycle wins; one later times out
        access(8'h82, 1'b0, 1'b1, 32'h0, 4'hF, TO - 1);
        access(8'h82, 1'b0, 1'b1, 32'h0, 4'hF, TO);
        access(8'h10, 1'b0, 1'b1, 32'h0, 4'hF, 0);

        // Random mix of mapped/unmapped/illegal reads and writes
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            else r = mapped_regions[$urandom_range(0, 4)];
            k  = int'($urandom_range(0, 5));
            we = (k == 0) || (k >= 3);
            re = (k >= 1) && (k <= 3);
            if (k >= 4) re = 1'b0;
            access(r, we, re, $urandom, 4'($urandom), int'($urandom_range(0, TO + 2)));
        end

        // Saturate the error counter with illegal accesses
        for (int t = 0; t < 300; t++) begin
            access(mapped_regions[$urandom_range(0, 4)], 1'b1, 1'b1, $urandom, 4'hF, 1);
        end
        check_eq("err_sat", 32'(err_count), 32'(255));

        // Reset during WAIT aborts without an ack
        s_ready = '0;
        bus.address    = {8'h10, 22'h0};
        bus.readenable = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset_n        = 1'b0;
        bus.readenable = 1'b0;
        s_ready        = 5'b00010;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_ack_err", 32'({bus.ack, bus.bus_err}), 32'(0));
        check_eq("abort_sel_strb", 32'({s_sel, s_we, s_re}), 32'(0));
        check_eq("abort_readdata", bus.readdata, 32'(0));
        check_eq("abort_err_count", 32'(err_count), 32'(0));
        reset_n   = 1'b1;
        s_ready   = '0;
        exp_rdata = '0;
        exp_errs  = 0;
        @(negedge clk);
        access(8'h00, 1'b0, 1'b1, 32'h0, 4'hF, 1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
